// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: opaque payload with valid/ready handshake,
// optional 2-entry skid buffer, masked flush and saturating debug counters.
module pipe_stage_reg #(
  parameter int               WIDTH    = 160,
  parameter logic [WIDTH-1:0] CLR_MASK = {WIDTH{1'b1}},
  parameter int               SKID     = 1,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // State value doubles as the number of beats held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] m_data_reg;
  logic [WIDTH-1:0] s_data_reg;
  logic             accept;
  logic             consume;
  logic             m_load;
  logic             s_load;
  logic             m_from_s;

  assign out_valid = (state_reg != EMPTY);
  assign out_data  = m_data_reg;
  assign occupancy = state_reg;
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  generate
    if (SKID != 0) begin : g_skid_ready
      // Depends on registered state only, so no path from out_ready.
      assign in_ready = !rst && (state_reg != TWO);
    end else begin : g_flow_ready
      assign in_ready = !rst && ((state_reg == EMPTY) || out_ready);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    m_load     = 1'b0;
    s_load     = 1'b0;
    m_from_s   = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            m_load     = 1'b1;
            state_next = ONE;
          end
        end
        ONE: begin
          // Without a skid register an accept only happens alongside a consume.
          if (accept && (consume || SKID == 0)) begin
            m_load = 1'b1;
          end else if (accept) begin
            s_load     = 1'b1;
            state_next = TWO;
          end else if (consume) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            m_from_s   = 1'b1;
            state_next = ONE;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // Flush zeroes only the masked control bits; datapath bits keep their value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data_reg <= '0;
    end else if (flush) begin
      m_data_reg <= m_data_reg & ~CLR_MASK;
    end else if (m_load) begin
      m_data_reg <= in_data;
    end else if (m_from_s) begin
      m_data_reg <= s_data_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_data_reg <= '0;
    end else if (s_load) begin
      s_data_reg <= in_data;
    end
  end

  logic [1:0]       cnt_event;
  logic [CNT_W-1:0] cnt_reg [2];

  assign cnt_event[0] = out_valid && !out_ready;
  assign cnt_event[1] = flush;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_event[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
          cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign stall_cnt = cnt_reg[0];
  assign flush_cnt = cnt_reg[1];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: a skid-buffered 16-bit stage with 4-bit counters and a
// non-skid stage, driven and sampled one time unit after each rising edge.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;

  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  occupancy;
  logic [3:0]  stall_cnt;
  logic [3:0]  flush_cnt;

  logic        n_flush;
  logic        n_in_valid;
  logic        n_in_ready;
  logic [15:0] n_in_data;
  logic        n_out_valid;
  logic        n_out_ready;
  logic [15:0] n_out_data;
  logic [1:0]  n_occupancy;
  logic [7:0]  n_stall_cnt;
  logic [7:0]  n_flush_cnt;

  int vectors;
  int miscompares;

  pipe_stage_reg #(
    .WIDTH(16), .CLR_MASK(16'h00FF), .SKID(1), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_stage_reg #(
    .WIDTH(16), .CLR_MASK(16'hFFFF), .SKID(0), .CNT_W(8)
  ) dut0 (
    .clk(clk), .rst(rst), .flush(n_flush),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
    .occupancy(n_occupancy), .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || occupancy !== 2'd0) begin
      miscompares++; $display("FAIL rst_init: got v=%b d=%h occ=%0d expected v=0 d=0000 occ=0", out_valid, out_data, occupancy);
    end
    step();
    step();
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready: got %b expected 1", in_ready); end
    // Build up occupancy 2, stall_cnt 5, flush_cnt 2.
    flush = 1'b1;
    step();
    step();
    flush = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0011;
    step();
    in_data = 16'h0022;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    vectors++;
    if (occupancy !== 2'd2 || stall_cnt !== 4'd5 || flush_cnt !== 4'd2) begin
      miscompares++; $display("FAIL rst_setup: got occ=%0d stall=%0d flush=%0d expected occ=2 stall=5 flush=2", occupancy, stall_cnt, flush_cnt);
    end
    #4;
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || occupancy !== 2'd0) begin
      miscompares++; $display("FAIL rst_async_state: got v=%b d=%h occ=%0d expected v=0 d=0000 occ=0", out_valid, out_data, occupancy);
    end
    vectors++;
    if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      miscompares++; $display("FAIL rst_async_cnt: got stall=%0d flush=%0d expected 0 0", stall_cnt, flush_cnt);
    end
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_pulse_ready: got %b expected 0", in_ready); end
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_after_ready: got %b expected 1", in_ready); end
    step();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 16'(i);
      #0;
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, in_ready); end
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 16'(i)) begin
        miscompares++; $display("FAIL stream_data[%0d]: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, 16'(i));
      end
      $display("stream beat %0d out_data=%h", i, out_data);
    end
    in_valid = 1'b0;
    step();
    vectors++;
    if (occupancy !== 2'd0 || stall_cnt !== 4'd0) begin
      miscompares++; $display("FAIL stream_end: got occ=%0d stall=%0d expected 0 0", occupancy, stall_cnt);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h00A1;
    step();
    in_data = 16'h00B2;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_one: got %b expected 1", in_ready); end
    step();
    in_data = 16'h00C3;
    step();
    step();
    vectors++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 16'h00A1) begin
      miscompares++; $display("FAIL bp_full: got occ=%0d rdy=%b d=%h expected occ=2 rdy=0 d=00a1", occupancy, in_ready, out_data);
    end
    out_ready = 1'b1;
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 16'h00B2) begin
      miscompares++; $display("FAIL bp_second: got v=%b d=%h expected v=1 d=00b2", out_valid, out_data);
    end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_back: got %b expected 1", in_ready); end
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 16'h00C3) begin
      miscompares++; $display("FAIL bp_third: got v=%b d=%h expected v=1 d=00c3", out_valid, out_data);
    end
    step();
    vectors++;
    if (out_valid !== 1'b0 || stall_cnt !== 4'd3) begin
      miscompares++; $display("FAIL bp_drain: got v=%b stall=%0d expected v=0 stall=3", out_valid, stall_cnt);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'hABCD;
    step();
    in_data = 16'h1234;
    step();
    in_data = 16'h5555;
    flush = 1'b1;
    step();
    vectors++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== 16'hAB00) begin
      miscompares++; $display("FAIL flush_state: got v=%b occ=%0d d=%h expected v=0 occ=0 d=ab00", out_valid, occupancy, out_data);
    end
    vectors++;
    if (flush_cnt !== 4'd1 || stall_cnt !== 4'd5) begin
      miscompares++; $display("FAIL flush_cnt: got flush=%0d stall=%0d expected 1 5", flush_cnt, stall_cnt);
    end
    // A beat accepted during flush must be discarded.
    out_ready = 1'b1;
    in_data = 16'h7777;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready: got %b expected 1", in_ready); end
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 16'hAB00 || flush_cnt !== 4'd2) begin
      miscompares++; $display("FAIL flush_discard: got v=%b d=%h flush=%0d expected v=0 d=ab00 flush=2", out_valid, out_data, flush_cnt);
    end
  endtask

  task automatic test_saturation();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0042;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    vectors++;
    if (stall_cnt !== 4'd10) begin miscompares++; $display("FAIL sat_mid: got %0d expected 10", stall_cnt); end
    repeat (15) step();
    vectors++;
    if (stall_cnt !== 4'd15) begin miscompares++; $display("FAIL sat_hold: got %0d expected 15", stall_cnt); end
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 16'h0042) begin
      miscompares++; $display("FAIL sat_stable: got v=%b d=%h expected v=1 d=0042", out_valid, out_data);
    end
    out_ready = 1'b1;
    step();
    vectors++;
    if (out_valid !== 1'b0 || stall_cnt !== 4'd15) begin
      miscompares++; $display("FAIL sat_drain: got v=%b stall=%0d expected v=0 stall=15", out_valid, stall_cnt);
    end
  endtask

  task automatic test_no_skid();
    n_out_ready = 1'b1;
    n_in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_in_data = 16'(16'h0100 + i);
      #0;
      vectors++;
      if (n_in_ready !== 1'b1) begin miscompares++; $display("FAIL ns_ready[%0d]: got %b expected 1", i, n_in_ready); end
      step();
      vectors++;
      if (n_out_valid !== 1'b1 || n_out_data !== 16'(16'h0100 + i) || n_occupancy !== 2'd1) begin
        miscompares++; $display("FAIL ns_data[%0d]: got v=%b d=%h occ=%0d expected v=1 d=%h occ=1", i, n_out_valid, n_out_data, n_occupancy, 16'(16'h0100 + i));
      end
    end
    n_in_valid  = 1'b0;
    n_out_ready = 1'b0;
    #1;
    vectors++;
    if (n_in_ready !== 1'b0) begin miscompares++; $display("FAIL ns_follow_lo: got %b expected 0", n_in_ready); end
    n_out_ready = 1'b1;
    #1;
    vectors++;
    if (n_in_ready !== 1'b1) begin miscompares++; $display("FAIL ns_follow_hi: got %b expected 1", n_in_ready); end
    n_out_ready = 1'b0;
    n_in_valid = 1'b1; n_in_data = 16'h0105;
    step();
    vectors++;
    if (n_out_data !== 16'h0104 || n_occupancy !== 2'd1 || n_stall_cnt !== 8'd1) begin
      miscompares++; $display("FAIL ns_blocked: got d=%h occ=%0d stall=%0d expected d=0104 occ=1 stall=1", n_out_data, n_occupancy, n_stall_cnt);
    end
    n_out_ready = 1'b1;
    step();
    n_in_valid = 1'b0;
    vectors++;
    if (n_out_data !== 16'h0105 || n_occupancy !== 2'd1) begin
      miscompares++; $display("FAIL ns_swap: got d=%h occ=%0d expected d=0105 occ=1", n_out_data, n_occupancy);
    end
    step();
    vectors++;
    if (n_out_valid !== 1'b0 || n_occupancy !== 2'd0) begin
      miscompares++; $display("FAIL ns_drain: got v=%b occ=%0d expected v=0 occ=0", n_out_valid, n_occupancy);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    n_flush = 1'b0; n_in_valid = 1'b0; n_in_data = '0; n_out_ready = 1'b0;
    #1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_no_skid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline stage register that replaces the fixed-field, hazard-code-driven inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the MIPS32 pipeline. It carries an opaque payload of configurable width with a valid/ready handshake. An optional 2-entry skid buffer makes `in_ready` a registered signal. It supports a synchronous flush with a per-bit clear mask, so control fields become a bubble while datapath fields keep their values. Saturating stall and flush counters support performance debug.

## Interface
- `WIDTH`, default 160: payload width in bits (≥1).
- `CLR_MASK`, default all ones (`WIDTH` bits): bits set to 1 are zeroed in `out_data` on flush.
- `SKID`, default 1: 1 = 2-entry skid buffer with registered `in_ready`; 0 = single register with combinational `in_ready`.
- `CNT_W`, default 16: width of the performance counters (≥2).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous kill of all held and incoming beats.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  stage can accept a beat.
- `in_data`  in  `WIDTH`  upstream payload.
- `out_valid`  out  1  downstream beat present.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  `WIDTH`  payload, driven directly from the main register.
- `occupancy`  out  2  beats held (0..2; never exceeds 1 when `SKID`=0).
- `stall_cnt`  out  `CNT_W`  saturating count of cycles with `out_valid` && !`out_ready`.
- `flush_cnt`  out  `CNT_W`  saturating count of cycles with `flush`=1.

## Operation
- Accept = `in_valid` && `in_ready`. Consume = `out_valid` && `out_ready`.
- Storage: main register M (valid flag plus payload) and, when `SKID`=1, skid register S (valid flag plus payload). `out_valid` = M.valid. `out_data` = M.payload.

State machine for `SKID`=1, encoded by occupancy:
- EMPTY:
  - Accept: M ← `in_data`, go to ONE.
  - Otherwise: stay.
- ONE:
  - Accept and consume: M ← `in_data`, stay.
  - Accept only: S ← `in_data`, go to TWO.
  - Consume only: go to EMPTY.
  - Neither: hold.
- TWO: `in_ready`=0.
  - Consume: M ← S, S invalid, go to ONE.
  - Otherwise: hold.
- `in_ready` = !S.valid (registered state only, no combinational path from `out_ready`).

`SKID`=0:
- `in_ready` = !M.valid || `out_ready`.
- Accept loads M. Consume without accept clears M.valid.

Flush (priority over everything except `rst`):
- Next state is EMPTY and both valid flags clear.
- `out_data` bits with `CLR_MASK`=1 become 0. Other bits keep their value. The S payload is don't-care.
- A beat accepted in the flush cycle is discarded.
- A consume in the flush cycle completes normally; downstream owns that beat.

Payload registers load only on accept or S→M move. `out_data` is otherwise stable, including while `out_valid`=0.

Counters:
- Increment by 1 on their condition and saturate at 2^`CNT_W`−1.
- Cleared only by `rst`; flush does not clear them.
- Stall and flush counting are independent and may both increment in the same cycle.

## Timing
- Reset values, applied asynchronously on `rst` rise:
  - `out_valid`=0, `out_data`=0, `occupancy`=0, `stall_cnt`=0, `flush_cnt`=0, S cleared.
  - `in_ready`=0 while `rst`=1, and 1 in the first cycle after deassert.
- Reset mid-operation discards all held beats immediately.
- Latency: a beat accepted at edge N is presented on `out_valid`/`out_data` after edge N, one cycle after acceptance.
- Throughput: 1 beat/cycle while `out_ready`=1, for both `SKID` settings.
- Backpressure (`SKID`=1): after `out_ready` falls, at most one further beat is accepted. `in_ready` falls one cycle after S fills and rises one cycle after S drains.
- Ordering is strictly FIFO. No beat is dropped or duplicated except by flush or `rst`.
- Handshake rules:
  - `out_valid`, once high, stays high with `out_data` unchanged until consume, flush, or `rst`.
  - `in_valid` may be withdrawn at any time; only accepted beats count.

## Test plan
- Reset: with occupancy 2, `stall_cnt`=5, `flush_cnt`=2, pulse `rst` between edges -> immediately `out_valid`=0, `out_data`=0, occupancy 0, both counters 0, `in_ready`=0 during `rst` and 1 after.
- Streaming (`SKID`=1, `out_ready`=1): feed 0x1..0x8 back-to-back -> `out_data` 0x1..0x8 each one cycle after its accept, `in_ready` constantly 1, `stall_cnt`=0.
- Backpressure: `out_ready`=0 for 3 cycles while offering A, B, C -> A in M, B in S, occupancy 2, `in_ready`=0, C held upstream. Release `out_ready` -> A, B, C emerge in order with no loss, `stall_cnt`=3.
- Flush: occupancy 2, `in_valid`=1, `flush`=1 for one cycle, `CLR_MASK`=0x…00FF, `out_data`=0xABCD -> next cycle `out_valid`=0, occupancy 0, `out_data`=0xAB00, `flush_cnt`=1, incoming beat never appears.
- Saturation (`CNT_W`=4): hold `out_valid`=1, `out_ready`=0 for 20 cycles -> `stall_cnt` reaches 15 and stays 15.
- `SKID`=0: with M full, toggle `out_ready` -> `in_ready` follows `out_ready` in the same cycle, occupancy never exceeds 1, back-to-back throughput is 1 beat/cycle.
